// File: rtl/spi_shift_engine.sv
// SPI serial shift engine: multi-word frames, 1..N bit words, MSB/LSB first.
// Samples on rising O_CLK, launches on falling O_CLK, requests stop on last bit.
module spi_shift_engine #(
  parameter int N = 8,
  parameter int M = 8,
  localparam int LW = $clog2(N)
) (
  input  logic          O_CLK,
  input  logic          I_RST_N,
  input  logic          I_EN,
  input  logic          I_LSB_FIRST,
  input  logic [LW-1:0] I_WORD_LEN,
  input  logic [M-1:0]  I_NUM_WORDS,
  input  logic [N-1:0]  I_TX_DATA,
  input  logic          I_TX_VALID,
  output logic          O_TX_READY,
  input  logic          I_MISO,
  output logic          O_MOSI,
  output logic [N-1:0]  O_RX_DATA,
  output logic          O_RX_VALID,
  output logic          O_LAST_CLK,
  output logic          O_BUSY,
  output logic          O_UNDERRUN
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LW:0] TOP = (LW+1)'(N - 1);

  state_t        state, state_nx;
  logic          lsb_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] bit_cnt;
  logic [M-1:0]  words_left;
  logic [N-1:0]  tx_sr;
  logic [N-1:0]  rx_sr;
  logic          mosi_q;

  logic          idle;
  logic          run;
  logic          wend;
  logic          lsb_e;
  logic [LW-1:0] len_e;
  logic [LW-1:0] cnt_e;
  logic [M-1:0]  wl_e;
  logic [N-1:0]  rx_base;
  logic [N-1:0]  rx_next;
  logic [LW:0]   sh;
  logic [N-1:0]  fill;

  // In IDLE the live inputs stand in for the latched config, so the
  // start edge goes through exactly the same datapath as a SHIFT edge.
  always_comb begin
    idle     = (state == IDLE);
    lsb_e    = idle ? I_LSB_FIRST : lsb_q;
    len_e    = idle ? I_WORD_LEN : len_q;
    cnt_e    = idle ? I_WORD_LEN : bit_cnt;
    wl_e     = idle ? I_NUM_WORDS : words_left;
    run      = I_EN & (~idle | I_TX_VALID);
    wend     = run & (cnt_e == '0);
    rx_base  = idle ? '0 : rx_sr;
    rx_next  = lsb_e
             ? ((rx_base >> 1) | ({{(N-1){1'b0}}, I_MISO} << len_e))
             : {rx_base[N-2:0], I_MISO};
    sh       = TOP - {1'b0, len_q};
    fill     = {N{1'b1}} >> sh;
    state_nx = state;
    if (!I_EN)
      state_nx = IDLE;
    else if (run)
      state_nx = (wend && wl_e == '0) ? IDLE : SHIFT;
  end

  always_ff @(posedge O_CLK or negedge I_RST_N) begin
    if (!I_RST_N)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge O_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      lsb_q      <= 1'b0;
      len_q      <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      O_RX_DATA  <= '0;
      O_RX_VALID <= 1'b0;
      O_UNDERRUN <= 1'b0;
    end else if (!I_EN) begin
      rx_sr      <= '0;
      O_RX_VALID <= 1'b0;
      O_UNDERRUN <= 1'b0;
    end else if (run) begin
      if (idle) begin
        lsb_q <= I_LSB_FIRST;
        len_q <= I_WORD_LEN;
        tx_sr <= I_TX_DATA;
      end
      if (wend) begin
        O_RX_DATA  <= rx_next;
        O_RX_VALID <= 1'b1;
        rx_sr      <= '0;
        if (wl_e != '0) begin
          words_left <= wl_e - M'(1);
          bit_cnt    <= len_e;
          if (!idle) begin
            if (I_TX_VALID) begin
              tx_sr <= I_TX_DATA;
            end else begin
              tx_sr      <= fill;
              O_UNDERRUN <= 1'b1;
            end
          end
        end
      end else begin
        rx_sr      <= rx_next;
        bit_cnt    <= cnt_e - LW'(1);
        words_left <= wl_e;
        O_RX_VALID <= 1'b0;
      end
    end else begin
      O_RX_VALID <= 1'b0;
    end
  end

  // bit_cnt is the index of the next bit in MSB order; mirror it for LSB.
  always_ff @(negedge O_CLK or negedge I_RST_N) begin
    if (!I_RST_N)
      mosi_q <= 1'b0;
    else if (state == SHIFT)
      mosi_q <= lsb_q ? tx_sr[len_q - bit_cnt] : tx_sr[bit_cnt];
  end

  assign O_MOSI = idle
                ? (I_LSB_FIRST ? I_TX_DATA[0] : I_TX_DATA[I_WORD_LEN])
                : mosi_q;

  assign O_TX_READY = I_EN
                    & (idle | (bit_cnt == '0 && words_left != '0));

  assign O_LAST_CLK = idle
                    ? (I_WORD_LEN == '0 && I_NUM_WORDS == '0)
                    : (bit_cnt == '0 && words_left == '0);

  assign O_BUSY = ~idle;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Testbench for spi_shift_engine: directed frames plus random frames
// checked against a frame-level bit-stream model.
module tb_spi_shift_engine;

  logic       clk;
  logic       I_RST_N;
  logic       I_EN;
  logic       I_LSB_FIRST;
  logic [2:0] I_WORD_LEN;
  logic [7:0] I_NUM_WORDS;
  logic [7:0] I_TX_DATA;
  logic       I_TX_VALID;
  logic       O_TX_READY;
  logic       I_MISO;
  logic       O_MOSI;
  logic [7:0] O_RX_DATA;
  logic       O_RX_VALID;
  logic       O_LAST_CLK;
  logic       O_BUSY;
  logic       O_UNDERRUN;

  int n_checks;
  int n_errors;

  logic [7:0] tx_w   [0:15];
  logic       vld_w  [0:15];
  logic [7:0] miso_w [0:15];
  logic [7:0] last_rx;

  spi_shift_engine #(.N(8), .M(8)) dut (
    .O_CLK       (clk),
    .I_RST_N     (I_RST_N),
    .I_EN        (I_EN),
    .I_LSB_FIRST (I_LSB_FIRST),
    .I_WORD_LEN  (I_WORD_LEN),
    .I_NUM_WORDS (I_NUM_WORDS),
    .I_TX_DATA   (I_TX_DATA),
    .I_TX_VALID  (I_TX_VALID),
    .O_TX_READY  (O_TX_READY),
    .I_MISO      (I_MISO),
    .O_MOSI      (O_MOSI),
    .O_RX_DATA   (O_RX_DATA),
    .O_RX_VALID  (O_RX_VALID),
    .O_LAST_CLK  (O_LAST_CLK),
    .O_BUSY      (O_BUSY),
    .O_UNDERRUN  (O_UNDERRUN)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  // One frame: MOSI must carry each word (or all-ones filler) in the
  // chosen bit order; RX words must equal what was driven on MISO.
  task automatic run_frame(input int len, input int nw, input bit lsb);
    logic [7:0] mask;
    logic [7:0] d;
    bit         und;
    bit         bnd;
    int         idx;
    mask = 8'((1 << len) - 1);
    und  = 1'b0;
    I_TX_VALID = 1'b0;
    I_EN = 1'b0;
    pulse();
    I_EN = 1'b1;
    check("clr_und", 32'(O_UNDERRUN), 32'd0);
    I_WORD_LEN  = 3'(len - 1);
    I_NUM_WORDS = 8'(nw);
    I_LSB_FIRST = lsb;
    I_TX_DATA   = tx_w[0];
    I_TX_VALID  = 1'b1;
    for (int w = 0; w <= nw; w++) begin
      d = vld_w[w] ? tx_w[w] : 8'hFF;
      for (int b = 0; b < len; b++) begin
        idx = lsb ? b : len - 1 - b;
        bnd = (b == len - 1) && (w < nw);
        I_MISO = miso_w[w][idx];
        if (bnd) begin
          I_TX_DATA  = tx_w[w+1];
          I_TX_VALID = vld_w[w+1];
        end
        #1;
        check("mosi", 32'(O_MOSI), 32'(d[idx]));
        check("last", 32'(O_LAST_CLK), 32'(w == nw && b == len - 1));
        check("busy", 32'(O_BUSY), 32'(!(w == 0 && b == 0)));
        if (bnd)
          check("txrdy", 32'(O_TX_READY), 32'd1);
        clk = 1'b1;
        #1;
        if (bnd && !vld_w[w+1])
          und = 1'b1;
        check("rxv", 32'(O_RX_VALID), 32'(b == len - 1));
        if (b == len - 1)
          check("rxd", 32'(O_RX_DATA), 32'(miso_w[w] & mask));
        check("und", 32'(O_UNDERRUN), 32'(und));
        #4;
        clk = 1'b0;
        #4;
      end
    end
    I_TX_VALID = 1'b0;
    #1;
    check("busy_end", 32'(O_BUSY), 32'd0);
    last_rx = miso_w[nw] & mask;
  endtask

  task automatic fill_words(input int nw);
    for (int i = 0; i <= nw; i++) begin
      tx_w[i]   = 8'($urandom);
      miso_w[i] = 8'($urandom);
      vld_w[i]  = (i == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clk         = 1'b0;
    I_RST_N     = 1'b0;
    I_EN        = 1'b1;
    I_LSB_FIRST = 1'b0;
    I_WORD_LEN  = 3'd7;
    I_NUM_WORDS = 8'd0;
    I_TX_DATA   = 8'h00;
    I_TX_VALID  = 1'b0;
    I_MISO      = 1'b0;
    last_rx     = 8'h00;
    #10;
    check("rst_busy", 32'(O_BUSY), 32'd0);
    check("rst_rxv", 32'(O_RX_VALID), 32'd0);
    check("rst_rxd", 32'(O_RX_DATA), 32'd0);
    check("rst_und", 32'(O_UNDERRUN), 32'd0);
    check("rst_txrdy", 32'(O_TX_READY), 32'd1);
    check("rst_last", 32'(O_LAST_CLK), 32'd0);
    I_RST_N = 1'b1;
    #10;

    tx_w[0] = 8'hC1; miso_w[0] = 8'h3C; vld_w[0] = 1'b1;
    run_frame(8, 0, 1'b0);
    run_frame(8, 0, 1'b1);

    tx_w[0] = 8'h13; miso_w[0] = 8'h16;
    run_frame(5, 0, 1'b0);

    tx_w[0] = 8'hAA; vld_w[0] = 1'b1;
    tx_w[1] = 8'h00; vld_w[1] = 1'b0;
    tx_w[2] = 8'h55; vld_w[2] = 1'b1;
    miso_w[0] = 8'h12; miso_w[1] = 8'hE7; miso_w[2] = 8'h9C;
    run_frame(8, 2, 1'b0);

    tx_w[0] = 8'h01; miso_w[0] = 8'h01;
    run_frame(1, 0, 1'b0);

    // Reset in the middle of an 8-bit frame
    I_WORD_LEN = 3'd7; I_NUM_WORDS = 8'd0; I_LSB_FIRST = 1'b0;
    I_TX_DATA = 8'hF0; I_TX_VALID = 1'b1; I_MISO = 1'b1;
    pulse(); pulse(); pulse();
    check("mid_busy", 32'(O_BUSY), 32'd1);
    I_RST_N = 1'b0;
    #1;
    check("arst_busy", 32'(O_BUSY), 32'd0);
    check("arst_rxv", 32'(O_RX_VALID), 32'd0);
    check("arst_rxd", 32'(O_RX_DATA), 32'd0);
    check("arst_und", 32'(O_UNDERRUN), 32'd0);
    #4;
    I_RST_N = 1'b1;
    I_TX_VALID = 1'b0;
    #5;
    tx_w[0] = 8'h81; miso_w[0] = 8'hA5; vld_w[0] = 1'b1;
    run_frame(8, 0, 1'b0);

    // Disable in the middle of a frame
    I_WORD_LEN = 3'd7; I_NUM_WORDS = 8'd1; I_LSB_FIRST = 1'b0;
    I_TX_DATA = 8'h3B; I_TX_VALID = 1'b1; I_MISO = 1'b0;
    pulse(); pulse(); pulse();
    I_EN = 1'b0;
    clk = 1'b1;
    #1;
    check("dis_busy", 32'(O_BUSY), 32'd0);
    check("dis_txrdy", 32'(O_TX_READY), 32'd0);
    check("dis_rxv", 32'(O_RX_VALID), 32'd0);
    check("dis_rxd", 32'(O_RX_DATA), 32'(last_rx));
    #4;
    clk = 1'b0;
    I_TX_VALID = 1'b0;
    #5;
    I_EN = 1'b1;

    for (int t = 0; t < 40; t++) begin
      int len;
      int nw;
      len = $urandom_range(2, 8);
      nw  = $urandom_range(0, 3);
      fill_words(nw);
      run_frame(len, nw, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
